// File: rtl/ysyx_23060025_pipe_stage.sv
// Inter-stage pipeline register with a valid/ready handshake, synchronous flush and saturating stall counter.
// Defining YSYX_23060025_PIPE_SKID_EN adds a second (skid) entry so in_ready becomes a pure register output.
module ysyx_23060025_pipe_stage #(
    parameter int DATA_WIDTH = 32,
    parameter     RESET_VAL  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Upstream keeps in_data stable while in_valid=1 and in_ready=0; out_valid only falls
    // after an output transfer, a flush or a reset.
    localparam logic [DATA_WIDTH-1:0] LP_RESET_VAL = DATA_WIDTH'($unsigned(RESET_VAL));
    localparam logic [CNT_WIDTH-1:0]  LP_CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  LP_CNT_MAX   = '1;

    logic                  r_main_valid;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_main_valid_nxt;
    logic [DATA_WIDTH-1:0] w_main_data_nxt;

    assign out_valid  = r_main_valid;
    assign out_data   = r_main_data;
    assign stall_cnt  = r_stall_cnt;
    assign w_out_fire = r_main_valid & out_ready;
    assign w_in_fire  = in_valid & in_ready;

`ifdef YSYX_23060025_PIPE_SKID_EN
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_in_ready;
    logic                  w_skid_valid_nxt;
    logic [DATA_WIDTH-1:0] w_skid_data_nxt;

    assign in_ready = r_in_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (flush) begin
            // Drop both entries; payload storage keeps its old contents.
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_out_fire || !r_main_valid) begin
            // Main slot frees up: refill from skid first to keep FIFO order.
            if (r_skid_valid) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = r_skid_data;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = in_data;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_in_fire) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= LP_RESET_VAL;
            r_in_ready   <= 1'b1;
        end else begin
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end
`else
    assign in_ready = ~r_main_valid | out_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
        end else if (w_in_fire) begin
            // Covers the simultaneous-fire case: the new payload replaces the old one.
            w_main_valid_nxt = 1'b1;
            w_main_data_nxt  = in_data;
        end else if (w_out_fire) begin
            w_main_valid_nxt = 1'b0;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= LP_RESET_VAL;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
        end
    end

    // Counts stalled cycles including a flush cycle; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && (r_stall_cnt != LP_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_pipe_stage.sv
// Directed scoreboard bench for ysyx_23060025_pipe_stage; works in both the base and the skid build.
module tb_ysyx_23060025_pipe_stage;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  stall_cnt;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          n_total;
  int          n_bad;

  ysyx_23060025_pipe_stage #(
    .DATA_WIDTH(32),
    .RESET_VAL (0),
    .CNT_WIDTH (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // monitor: every output transfer pops the oldest expected payload
  always @(negedge clock) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out got=%h exp=none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          n_bad++;
          $display("FAIL out_data got=%h exp=%h", out_data, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // driver: one clock cycle; an input transfer pushes its payload to the scoreboard
  task automatic step();
    logic acc;
    @(negedge clock);
    acc = in_valid && in_ready && !flush && !reset;
    if (acc) exp_q.push_back(in_data);
    @(posedge clock);
    #1;
    if (acc) in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    while (in_valid && k < 20) begin
      step();
      k++;
    end
    if (in_valid) begin
      n_total++;
      n_bad++;
      $display("FAIL send_timeout got=%h exp=accepted", d);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // reset hold
    do_reset();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_stall_cnt", {28'b0, stall_cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // streaming, one cycle latency, no gaps
    out_ready = 1'b1;
    send(32'h1);
    chk("stream_v1", {31'b0, out_valid}, 32'd1);
    chk("stream_d1", out_data, 32'h1);
    send(32'h2);
    chk("stream_v2", {31'b0, out_valid}, 32'd1);
    chk("stream_d2", out_data, 32'h2);
    send(32'h3);
    chk("stream_v3", {31'b0, out_valid}, 32'd1);
    chk("stream_d3", out_data, 32'h3);
    in_data = 32'hEE;
    step();
    chk("stream_drain_v", {31'b0, out_valid}, 32'd0);
    chk("stream_hold_data", out_data, 32'h3);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    send(32'hA);
    in_valid = 1'b1;
    in_data  = 32'hB;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    chk("bp_out_data", out_data, 32'hA);
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_stall_cnt", {28'b0, stall_cnt}, 32'd5);
`ifdef YSYX_23060025_PIPE_SKID_EN
    chk("bp_skid_accepted", exp_q.size(), 32'd2);
`else
    chk("bp_base_pending", exp_q.size(), 32'd1);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (exp_q.size() != 0 || in_valid); i++) step();
    chk("bp_drain_v", {31'b0, out_valid}, 32'd0);
    chk("bp_drain_q", exp_q.size(), 32'd0);
    chk("bp_drain_rdy", {31'b0, in_ready}, 32'd1);
    chk("bp_stall_keep", {28'b0, stall_cnt}, 32'd5);

    // flush of held entries
    do_reset();
    out_ready = 1'b0;
    send(32'h55);
`ifdef YSYX_23060025_PIPE_SKID_EN
    send(32'h66);
`endif
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h77;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
    chk("fl_data_kept", out_data, 32'h55);
`ifdef YSYX_23060025_PIPE_SKID_EN
    chk("fl_stall_cnt", {28'b0, stall_cnt}, 32'd2);
`else
    chk("fl_stall_cnt", {28'b0, stall_cnt}, 32'd1);
`endif
    out_ready = 1'b1;
    repeat (3) step();
    chk("fl_idle_v", {31'b0, out_valid}, 32'd0);
    // flush while ready: offered payload is still discarded
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h99;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl2_data_kept", out_data, 32'h55);
    step();
    chk("fl2_idle_v", {31'b0, out_valid}, 32'd0);

    // stall counter saturation
    do_reset();
    out_ready = 1'b0;
    send(32'h5A);
    repeat (10) step();
    chk("sat_mid", {28'b0, stall_cnt}, 32'd10);
    repeat (10) step();
    chk("sat_max", {28'b0, stall_cnt}, 32'hF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    chk("sat_flush_keep", {28'b0, stall_cnt}, 32'hF);
    chk("sat_flush_v", {31'b0, out_valid}, 32'd0);
    do_reset();
    chk("sat_reset_clr", {28'b0, stall_cnt}, 32'd0);

    // simultaneous input and output fire
    out_ready = 1'b0;
    send(32'h10);
    out_ready = 1'b1;
    send(32'h20);
    chk("sim_out_data", out_data, 32'h20);
    chk("sim_out_valid", {31'b0, out_valid}, 32'd1);
    step();
    chk("sim_drain_v", {31'b0, out_valid}, 32'd0);
    chk("sim_drain_q", exp_q.size(), 32'd0);
    chk("sim_stall_cnt", {28'b0, stall_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_pipe_stage.md
Name: ysyx_23060025_pipe_stage

Overview:
- Generic, parametrised inter-stage pipeline register for the IFU/IDU/EXU/LSU/WBU chain.
- Carries one packed payload bus under a full valid/ready handshake, instead of one register per field with a load enable.
- Adds three things: backpressure-correct bubble handling, a synchronous flush for redirects, and a saturating stall counter.
- An optional skid buffer breaks the combinational ready path between stages.

Parameters:
- DATA_WIDTH, 32: payload width in bits; any value >= 1.
- RESET_VAL, 0: value loaded into every payload register on reset (truncated or zero-extended to DATA_WIDTH).
- CNT_WIDTH, 16: width of the stall counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries (branch/exception redirect).
- in_valid  in  1  upstream offers payload.
- in_ready  out  1  stage can accept payload this cycle.
- in_data  in  DATA_WIDTH  upstream payload.
- out_valid  out  1  stage holds a payload for downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_WIDTH  payload presented downstream.
- stall_cnt  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Clock and reset: single clock domain. reset is synchronous and active-high and has priority over everything else.
- Reset values: out_valid=0, out_data=RESET_VAL, stall_cnt=0. in_ready=1 in the first cycle after reset in both build modes.
- Transfer definitions: input fire = in_valid & in_ready; output fire = out_valid & out_ready.
- Handshake rules:
  - Payload must be held stable by the upstream while in_valid=1 and in_ready=0; the stage never drops accepted data.
  - out_data is driven directly from a register; there is no combinational path from in_data to out_data.
  - out_valid must not fall without an output fire, except on flush or reset.
- Latency and throughput:
  - Latency is 1 cycle: a payload accepted at edge N is visible on out_data/out_valid after edge N.
  - Sustained throughput is 1 transfer per cycle when out_ready stays high.
- Base mode (macro off), single entry:
  - in_ready = ~out_valid | out_ready (combinational).
  - On input fire: main register <= in_data and out_valid <= 1.
  - On output fire without input fire: out_valid <= 0, and out_data keeps its value.
  - Simultaneous input and output fire: the new payload replaces the old one and out_valid stays 1.
  - Without an input fire, the main register is not written (no bubble overwrite).
- Flush:
  - On a cycle with flush=1, all valid bits clear at the edge.
  - in_data offered in the flush cycle is discarded, even if in_valid & in_ready.
  - Payload registers keep their contents.
  - in_ready=1 in the following cycle.
  - An output fire occurring in the flush cycle still counts as consumed by downstream; the stage takes no action on it.
- stall_cnt:
  - Increments by 1 each cycle with out_valid=1 and out_ready=0, including a flush cycle.
  - Holds at 2^CNT_WIDTH-1; no wrap.
  - Cleared only by reset; flush does not clear it.
- Invariant: the stage never presents out_valid=1 with data that was not accepted via an input fire since the last flush or reset.

Optional Feature:
- Macro: YSYX_23060025_PIPE_SKID_EN.
- When defined, the stage holds two entries: main and skid.
- in_ready is a pure register output: in_ready = ~skid_valid, registered.
- Input fire while the main entry is valid and there is no output fire: the payload goes to skid, skid_valid <= 1, and in_ready drops next cycle.
- Output fire while skid_valid=1: skid moves into main, and skid_valid <= 0 unless a simultaneous input fire refills it. In skid mode in_ready=0 whenever skid_valid=1, so no input fire can occur in that cycle.
- Ordering is strictly FIFO; throughput is still 1 per cycle.
- Flush clears both valid bits.
- When not defined: the base single-entry behaviour above, with no skid storage synthesised.

Test Plan:
- Reset hold: assert reset 2 cycles with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, out_data=0x00000000, stall_cnt=0, in_ready=1 after release.
- Streaming: out_ready=1, push 0x1,0x2,0x3 back-to-back -> out_data 0x1,0x2,0x3 on consecutive cycles, each one cycle after its input fire, with no gaps.
- Backpressure: push 0xA, then 0xB, then hold out_ready=0 for 5 cycles -> out_data stays 0xA, stall_cnt=5. In base mode in_ready=0 while stalled. In skid mode 0xB is accepted and in_ready=0 afterwards. Releasing out_ready delivers 0xA then 0xB, in order.
- Flush: stage holding 0x55 (and 0x66 in skid), assert flush with in_valid=1, in_data=0x77 -> next cycle out_valid=0, in_ready=1. 0x77 never appears on out_data.
- Saturation: CNT_WIDTH=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 0xF; flush does not clear it; reset clears it to 0.
- Simultaneous fire (base mode): out_valid=1 holding 0x10, out_ready=1, in_valid=1 with 0x20 -> next cycle out_data=0x20, out_valid=1, no lost or duplicated transfer.
